limber_gnrl_skidbuf: RTL and testbench
======================================

LIMBER_GNRL_SKIDBUF -- requirements
Module: limber_gnrl_skidbuf

Interface
REQ-001 SHALL have parameter DW, default 8, giving the payload width in bits (DW >= 1).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_vld  input  1  upstream payload valid.
REQ-005 SHALL have port i_rdy  output  1  buffer can accept; driven directly from a register.
REQ-006 SHALL have port i_dat  input  DW  upstream payload.
REQ-007 SHALL have port o_vld  output  1  downstream payload valid.
REQ-008 SHALL have port o_rdy  input  1  downstream accepts.
REQ-009 SHALL have port o_dat  output  DW  downstream payload; driven from the main register.

Function
REQ-010 SHALL transfer on a side only when vld and rdy are both 1 at a rising edge of clk.
REQ-011 SHALL hold two DW-bit registers, main and skid, and a state machine with three states:
- EMPTY: 0 entries
- BUSY: main valid
- FULL: main and skid valid
REQ-012 SHALL make the following transitions from EMPTY:
- in-handshake -> BUSY, main<=i_dat
- otherwise stay
REQ-013 SHALL make the following transitions from BUSY:
- in only -> FULL, skid<=i_dat
- out only -> EMPTY
- in and out -> BUSY, main<=i_dat
- neither -> stay
REQ-014 SHALL make the following transitions from FULL:
- out-handshake -> BUSY, main<=skid
- otherwise stay
- no input is accepted in FULL
REQ-015 SHALL drive o_vld=1 exactly in BUSY or FULL, and i_rdy=1 exactly in EMPTY or BUSY; i_rdy SHALL be a flop output with no combinational path from o_rdy.
REQ-016 SHALL present a word accepted at edge N on o_dat after edge N (latency 1 cycle) if the buffer was EMPTY.
REQ-017 SHALL sustain 1 transfer per cycle with o_rdy held 1.
REQ-018 SHALL preserve strict FIFO order; no word dropped or duplicated.
REQ-019 SHALL hold o_dat and o_vld stable while o_vld=1 and o_rdy=0.
REQ-020 SHALL handle simultaneous in/out in FULL as out only; i_rdy is 0, so any i_vld in that cycle is not a handshake.
REQ-021 SHALL keep the main register unchanged when no handshake occurs.

Reset
REQ-022 SHALL, at an edge with rst=1, go to EMPTY, clear main and skid to 0, and set o_vld=0, i_rdy=1, o_dat=0.
REQ-023 SHALL, when rst is asserted mid-operation (BUSY or FULL), discard contents; any handshake at that edge is ignored.
REQ-024 SHALL give rst priority over all other events.

Configuration
REQ-025 SHALL, when macro LIMBER_GNRL_SKIDBUF_STALL_CNT_EN is defined:
- add output port stall_cnt, 16 bits
- count cycles with o_vld=1 and o_rdy=0
- saturate at 16'hFFFF
- reset to 0 on rst
REQ-026 SHALL, when LIMBER_GNRL_SKIDBUF_STALL_CNT_EN is undefined:
- omit the stall_cnt port and its logic
- keep all other behaviour identical

Verification
REQ-027 SHALL cover single word: DW=8, i_vld=1 with 8'hA5 for one cycle, o_rdy=1 -> o_vld=1 with o_dat=8'hA5 the next cycle, then o_vld=0.
REQ-028 SHALL cover streaming: 16 words 0..15 with i_vld=1 and o_rdy=1 continuously -> outputs 0..15 on consecutive cycles, i_rdy always 1.
REQ-029 SHALL cover backpressure: send 8'h11, 8'h22 with o_rdy=0 -> FULL, i_rdy=0; then o_rdy=1 -> 8'h11 then 8'h22, i_rdy=1 after the first pop.
REQ-030 SHALL cover reset mid-operation: FULL, then rst=1 for one edge -> o_vld=0, i_rdy=1, o_dat=0 next cycle; no stale words emitted later.
REQ-031 SHALL cover random stress: random i_vld and o_rdy for 10000 cycles against a scoreboard -> order exact, no loss, o_dat stable while stalled.
REQ-032 SHALL cover the counter with LIMBER_GNRL_SKIDBUF_STALL_CNT_EN defined: hold o_vld=1 and o_rdy=0 for 70000 cycles -> stall_cnt=16'hFFFF and it stays there.

Source files
------------

// File: rtl/limber_gnrl_skidbuf.sv
// Two-entry skid buffer (main + skid register); registered i_rdy/o_vld; optional stall counter via LIMBER_GNRL_SKIDBUF_STALL_CNT_EN.
// Latency 1 cycle when empty; full throughput with o_rdy high; i_rdy drops only when both registers hold data.
// Backpressure: o_rdy low holds o_vld/o_dat stable, and the skid register absorbs one extra word before i_rdy deasserts.
module limber_gnrl_skidbuf #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_vld,
   output logic          i_rdy,
   input  logic [DW-1:0] i_dat,
   output logic          o_vld,
   input  logic          o_rdy,
   output logic [DW-1:0] o_dat
`ifdef LIMBER_GNRL_SKIDBUF_STALL_CNT_EN
   ,
   output logic [15:0]   stall_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_nxt;
   logic [DW-1:0] main_q;
   logic [DW-1:0] main_nxt;
   logic [DW-1:0] skid_q;
   logic [DW-1:0] skid_nxt;
   logic          i_rdy_q;
   logic          i_rdy_nxt;
   logic          o_vld_q;
   logic          o_vld_nxt;
   logic          in_hs;
   logic          out_hs;

   assign in_hs  = i_vld & i_rdy_q;
   assign out_hs = o_vld_q & o_rdy;

   // Handshake flags are registered alongside the state so neither ready nor valid has a comb path.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         i_rdy_q <= 1'b1;
         o_vld_q <= 1'b0;
      end else begin
         state_q <= state_nxt;
         main_q  <= main_nxt;
         skid_q  <= skid_nxt;
         i_rdy_q <= i_rdy_nxt;
         o_vld_q <= o_vld_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_hs) begin
               state_nxt = ST_BUSY;
               main_nxt  = i_dat;
            end
         end
         ST_BUSY: begin
            if (in_hs && out_hs) begin
               main_nxt = i_dat;
            end else if (in_hs) begin
               state_nxt = ST_FULL;
               skid_nxt  = i_dat;
            end else if (out_hs) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // i_rdy is low here, so only the output side can move.
            if (out_hs) begin
               state_nxt = ST_BUSY;
               main_nxt  = skid_q;
            end
         end
         default: begin
            state_nxt = ST_EMPTY;
         end
      endcase
   end

   always_comb begin
      i_rdy_nxt = (state_nxt != ST_FULL);
      o_vld_nxt = (state_nxt != ST_EMPTY);
   end

   assign i_rdy = i_rdy_q;
   assign o_vld = o_vld_q;
   assign o_dat = main_q;

`ifdef LIMBER_GNRL_SKIDBUF_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   // Saturating count of cycles where data waits on the downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (o_vld_q && !o_rdy && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_limber_gnrl_skidbuf.sv
// Bench for limber_gnrl_skidbuf: directed scenarios then random stress against a queue reference model.
module tb_limber_gnrl_skidbuf;

   logic       clk;
   logic       rst;
   logic       i_vld;
   logic       i_rdy;
   logic [7:0] i_dat;
   logic       o_vld;
   logic       o_rdy;
   logic [7:0] o_dat;
`ifdef LIMBER_GNRL_SKIDBUF_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   limber_gnrl_skidbuf #(.DW(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .i_vld (i_vld),
      .i_rdy (i_rdy),
      .i_dat (i_dat),
      .o_vld (o_vld),
      .o_rdy (o_rdy),
      .o_dat (o_dat)
`ifdef LIMBER_GNRL_SKIDBUF_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] q[$];
   logic [7:0] m_last = 8'h00;
   int         m_stall = 0;
   logic       prev_stalled = 1'b0;
   logic [7:0] prev_dat = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("o_vld", {31'd0, o_vld}, {31'd0, q.size() > 0});
      chk("i_rdy", {31'd0, i_rdy}, {31'd0, q.size() < 2});
      chk("o_dat", {24'd0, o_dat}, {24'd0, (q.size() > 0) ? q[0] : m_last});
      if (prev_stalled) chk("stall_hold", {24'd0, o_dat}, {24'd0, prev_dat});
`ifdef LIMBER_GNRL_SKIDBUF_STALL_CNT_EN
      chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
   endtask

   // Inputs change at the falling edge; outputs are checked one falling edge later.
   task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic rs);
      logic do_in;
      logic do_out;
      prev_stalled = o_vld && !r && !rs;
      prev_dat     = o_dat;
      i_vld = v;
      i_dat = d;
      o_rdy = r;
      rst   = rs;
      @(posedge clk);
      if (rs) begin
         q.delete();
         m_last  = 8'h00;
         m_stall = 0;
      end else begin
         do_out = (q.size() > 0) && r;
         do_in  = v && (q.size() < 2);
         if ((q.size() > 0) && !r && (m_stall < 65535)) m_stall++;
         if (do_out) m_last = q.pop_front();
         if (do_in) q.push_back(d);
      end
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      rst   = 1'b1;
      i_vld = 1'b0;
      i_dat = 8'h00;
      o_rdy = 1'b0;
      @(negedge clk);

      // Reset state
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("rst_o_vld", {31'd0, o_vld}, 32'd0);
      chk("rst_i_rdy", {31'd0, i_rdy}, 32'd1);
      chk("rst_o_dat", {24'd0, o_dat}, 32'd0);

      // Single word
      cyc(1'b1, 8'hA5, 1'b1, 1'b0);
      chk("single_vld", {31'd0, o_vld}, 32'd1);
      chk("single_dat", {24'd0, o_dat}, 32'hA5);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("single_drain", {31'd0, o_vld}, 32'd0);

      // Streaming at one word per cycle
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 8'(i), 1'b1, 1'b0);
         chk("stream_dat", {24'd0, o_dat}, i);
         chk("stream_vld", {31'd0, o_vld}, 32'd1);
         chk("stream_rdy", {31'd0, i_rdy}, 32'd1);
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("stream_end", {31'd0, o_vld}, 32'd0);

      // Backpressure into FULL, then drain
      cyc(1'b1, 8'h11, 1'b0, 1'b0);
      cyc(1'b1, 8'h22, 1'b0, 1'b0);
      chk("bp_full_rdy", {31'd0, i_rdy}, 32'd0);
      chk("bp_full_dat", {24'd0, o_dat}, 32'h11);
      cyc(1'b1, 8'h2F, 1'b0, 1'b0);
      chk("bp_hold_dat", {24'd0, o_dat}, 32'h11);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("bp_pop1_dat", {24'd0, o_dat}, 32'h22);
      chk("bp_pop1_rdy", {31'd0, i_rdy}, 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("bp_empty", {31'd0, o_vld}, 32'd0);

      // FULL with i_vld and o_rdy both high: the pop happens, the input is refused
      cyc(1'b1, 8'h44, 1'b0, 1'b0);
      cyc(1'b1, 8'h55, 1'b0, 1'b0);
      cyc(1'b1, 8'h66, 1'b1, 1'b0);
      chk("full_inout_dat", {24'd0, o_dat}, 32'h55);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("full_inout_drop", {31'd0, o_vld}, 32'd0);

      // Reset while FULL, with a would-be handshake on the same edge
      cyc(1'b1, 8'h77, 1'b0, 1'b0);
      cyc(1'b1, 8'h88, 1'b0, 1'b0);
      cyc(1'b1, 8'h99, 1'b1, 1'b1);
      chk("midrst_vld", {31'd0, o_vld}, 32'd0);
      chk("midrst_rdy", {31'd0, i_rdy}, 32'd1);
      chk("midrst_dat", {24'd0, o_dat}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("midrst_nostale", {31'd0, o_vld}, 32'd0);
      end

      // Random stress
      for (int i = 0; i < 10000; i++) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 3) != 0 ? 1 : 0) & 1'($urandom_range(0, 1) | (i % 7 == 0 ? 0 : 1)),
             1'b0);
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("stress_drained", {31'd0, o_vld}, 32'd0);

`ifdef LIMBER_GNRL_SKIDBUF_STALL_CNT_EN
      // Stall counter saturation
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("cnt_rst", {16'd0, stall_cnt}, 32'd0);
      cyc(1'b1, 8'h3C, 1'b0, 1'b0);
      for (int i = 0; i < 70000; i++) begin
         i_vld = 1'b0;
         o_rdy = 1'b0;
         @(negedge clk);
         if (m_stall < 65535) m_stall++;
      end
      chk("cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("cnt_stay", {16'd0, stall_cnt}, 32'h0000FFFF);
      chk("cnt_dat", {24'd0, o_dat}, 32'h3C);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
